muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside alu. It takes the same ID/EX operand bus (din0=rs, din1=rt).
- Owns the HI/LO architectural registers.
- The EX result mux selects hi/lo for MFHI/MFLO, in place of alurst.
- busy drives the hazard unit so the pipeline stalls any later mul/div/MFHI/MFLO/MTHI/MTLO. flush aborts an op on an interrupt or exception.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- start  input  1  issue md_op this cycle (EX-stage valid mul/div/move op).
- md_op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- din0  input  WIDTH  rs operand (multiplicand/dividend/MT source).
- din1  input  WIDTH  rt operand (multiplier/divisor).
- flush  input  1  pipeline flush from interrupt/exception logic.
- busy  output  1  iterative op in progress.
- done  output  1  one-cycle pulse when HI/LO are written by a mul/div.
- hi  output  WIDTH  HI register, read combinationally by the EX mux.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst=1 at a rising edge):
  - hi=0, lo=0, busy=0, done=0.
  - FSM goes to IDLE; any in-progress op is discarded.
  - rst has priority over everything.
- FSM states: IDLE, CALC, WRITE.
- In IDLE, a start with flush=0 is accepted:
  - MTHI: hi<=din0 at that edge, no busy, no done. MTLO: same for lo.
  - MULT/MULTU/DIV/DIVU: latch operands and op, go to CALC, busy=1 from the next cycle.
- Accepted-op timing, with the accept edge called T:
  - CALC performs one iteration per edge, T+1..T+32.
  - At T+32 the FSM goes to WRITE.
  - At T+33 hi/lo are written, done=1 for the cycle after T+33, busy=0, FSM returns to IDLE.
  - busy is high for exactly 33 cycles. A new op may be accepted at T+33 or later.
- start while busy=1 is ignored, including MTHI/MTLO. The hazard unit guarantees a stall; the bench checks the ignore.
- Multiply:
  - Shift-add over the operand magnitudes; 64-bit product gives hi=product[63:32], lo=product[31:0].
  - MULT: magnitudes of signed operands; the product is negated (two's complement, 64 bit) if the operand signs differ.
  - MULTU: raw unsigned operands.
- Divide:
  - Restoring division on magnitudes; lo=quotient, hi=remainder.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - DIVU: unsigned.
  - Divisor zero (DIV or DIVU): lo=0xFFFFFFFF, hi=din0 unmodified. Still 33 busy cycles.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Flush:
  - flush=1 in IDLE blocks acceptance of start in the same cycle, including MTHI/MTLO.
  - flush=1 in CALC or WRITE: next state IDLE, busy=0 next cycle, done stays 0, hi/lo unchanged.
  - No partial-result writeback on abort.
- Overflow/exceptions: none raised. All arithmetic is full-width 64-bit internally.

Decomposition:
- Add defines to ctrl_encode_define.v: MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5.
- Add the FSM state encodings to the same file.
- One sub-module, md_iter_core: a shared 64-bit shift register plus adder/subtractor performing one multiply or divide step per cycle on magnitudes.
- The top level does sign pre/post-correction, the FSM, and HI/LO.

Test Plan:
1. MULT din0=0xFFFFFFFE, din1=3 -> busy high 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI 0x11, MTLO 0x22, then DIV 100/3 with flush at the 10th busy cycle -> busy=0 next cycle, no done, hi=0x11, lo=0x22. Then DIVU 100/3 -> lo=33, hi=1.
5. start MTHI 0x55 and a second MULT while busy -> both ignored; the first op's result lands unaltered.
6. start with flush both high in IDLE -> no acceptance. rst asserted mid-CALC -> hi=lo=0, busy=0 next cycle.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// md_op_e    : operation codes carried on md_op (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// md_state_e : control FSM states (IDLE, CALC, WRITE).
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage bus between the pipeline and the multiply/divide unit.
// Pipeline side (master) drives start, md_op, din0 (rs), din1 (rt), flush.
// Unit side (slave) drives busy, done, hi, lo.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, din0, din1, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, din0, din1, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit_md_iter_core.sv
// md_iter_core: one unsigned multiply or restoring-divide step per cycle.
// Ports:
//   clk     : clock
//   load    : latch magnitudes a/b and mode is_div, clear the accumulator top half
//   step    : perform one iteration
//   is_div  : 1 = divide (a dividend, b divisor), 0 = multiply (a * b)
//   a, b    : operand magnitudes
//   res_hi  : product[2W-1:W] or remainder
//   res_lo  : product[W-1:0] or quotient
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   m;
  logic               div_mode;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   sh;
  logic [WIDTH-1:0]   rem_trial;
  logic               ge;

  always_comb begin
    // Multiply: acc = {partial, multiplier}; add m when the multiplier LSB is set, then shift right.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};
    mul_next = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract on W+1 bits
    // because the shifted remainder can momentarily exceed W bits.
    sh        = {acc, 1'b0};
    ge        = (sh[2*WIDTH:WIDTH] >= {1'b0, m});
    rem_trial = sh[2*WIDTH-1:WIDTH] - m;
    div_next  = ge ? {rem_trial, sh[WIDTH-1:1], 1'b1} : sh[2*WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (load) begin
      div_mode <= is_div;
      m        <= is_div ? b : a;
      acc      <= {{WIDTH{1'b0}}, (is_div ? a : b)};
    end else if (step) begin
      acc <= div_mode ? div_next : mul_next;
    end
  end

  assign res_hi = acc[2*WIDTH-1:WIDTH];
  assign res_lo = acc[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO registers (EX stage).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (clears HI/LO, busy, done, FSM)
//   bus  : muldiv_unit_if.slave -- start/md_op/din0/din1/flush in, busy/done/hi/lo out
// Signed ops are done on magnitudes in md_iter_core; sign correction happens at writeback.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e          state_q, state_d;
  md_op_e             op_in;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q, neg_r, dz_q, div_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               accept, core_step, wr_en, mt_hi, mt_lo;
  logic               in_signed, in_div, in_md, idle_take;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   core_hi, core_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   wr_hi, wr_lo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_wide(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_narrow(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  always_comb begin
    op_in     = md_op_e'(bus.md_op);
    in_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
    in_div    = (op_in == MD_DIV) || (op_in == MD_DIVU);
    in_md     = op_in inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    a_mag     = mag(bus.din0, in_signed);
    b_mag     = mag(bus.din1, in_signed);
    idle_take = (state_q == ST_IDLE) && bus.start && !bus.flush;
    mt_hi     = idle_take && (op_in == MD_MTHI);
    mt_lo     = idle_take && (op_in == MD_MTLO);
  end

  // FSM next state and control strobes
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    core_step = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (idle_take && in_md) begin
          accept  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          core_step = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        wr_en   = !bus.flush;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= wr_en;
    end
  end

  // Operand capture at accept; datapath registers carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cnt_q   <= '0;
      neg_q   <= in_signed && (bus.din0[WIDTH-1] ^ bus.din1[WIDTH-1]);
      neg_r   <= in_signed && in_div && bus.din0[WIDTH-1];
      dz_q    <= in_div && (bus.din1 == '0);
      div_q   <= in_div;
      a_raw_q <= bus.din0;
    end else if (core_step) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .load   (accept),
    .step   (core_step),
    .is_div (in_div),
    .a      (a_mag),
    .b      (b_mag),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  // Writeback sign correction; a zero divisor returns all-ones quotient and the raw dividend.
  always_comb begin
    prod = neg_wide({core_hi, core_lo}, neg_q);
    if (div_q) begin
      if (dz_q) begin
        wr_lo = '1;
        wr_hi = a_raw_q;
      end else begin
        wr_lo = neg_narrow(core_lo, neg_q);
        wr_hi = neg_narrow(core_hi, neg_r);
      end
    end else begin
      wr_hi = prod[2*WIDTH-1:WIDTH];
      wr_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr_en) begin
      hi_q <= wr_hi;
      lo_q <= wr_lo;
    end else begin
      if (mt_hi) hi_q <= bus.din0;
      if (mt_lo) lo_q <= bus.din0;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
